// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-rate counter: counts 0..lim and flags the last cycle of each bit.
module uart_bit_timer #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_lim,
    output logic             o_bit_end
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_lim;

    assign w_at_lim  = (r_cnt == i_lim);
    assign o_bit_end = i_en && w_at_lim;

    // Counter wraps at lim, so the all-ones limit never overflows; clr wins over en.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_lim ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, DATA_BITS data bits LSB first, optional
// even parity (UART_TX_PARITY_EN), STOP_BITS stop bits. tx_out is registered
// from the next-state decode so it changes in the same cycle as the state.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int CNT_W     = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CNT_W-1:0]     i_limit,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_out,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    state_t               r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_sh, w_sh_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [CNT_W-1:0]     r_lim_q;
    logic                 r_tx_out, r_busy, r_done;
    logic                 w_tx_nxt, w_done_nxt, w_clr, w_accept, w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 r_par;
`endif

    assign w_accept  = (r_state == IDLE) && i_tx_start;
    assign o_tx_out  = r_tx_out;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

    uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_clr),
        .i_en      (r_state != IDLE),
        .i_lim     (r_lim_q),
        .o_bit_end (w_bit_end)
    );

    // Next state, shift register, bit index, and the line level to register.
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_idx_nxt   = r_idx;
        w_clr       = 1'b0;
        w_done_nxt  = 1'b0;
        w_tx_nxt    = IDLE_LEVEL;
        case (r_state)
            IDLE: begin
                if (i_tx_start) begin
                    w_state_nxt = START;
                    w_sh_nxt    = i_tx_data;
                    w_idx_nxt   = '0;
                    w_clr       = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_idx_nxt   = '0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_idx < LAST_DATA) begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_sh_nxt  = r_sh >> 1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                        w_idx_nxt   = '0;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_idx_nxt   = '0;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    if (r_idx == LAST_STOP) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_sh_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_nxt = r_par;
`endif
            default: w_tx_nxt = IDLE_LEVEL;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_sh     <= '0;
            r_idx    <= '0;
            r_lim_q  <= '0;
            r_tx_out <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sh     <= w_sh_nxt;
            r_idx    <= w_idx_nxt;
            r_tx_out <= w_tx_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= w_done_nxt;
            if (w_accept) r_lim_q <= i_limit;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the frame's data, captured once at accept.
    always_ff @(posedge i_clk) begin
        if (i_rst)         r_par <= 1'b0;
        else if (w_accept) r_par <= ^i_tx_data;
    end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl; expected line waveform is built
// per frame from the framing rules (honours UART_TX_PARITY_EN).
module tb_uart_tx_ctrl;

    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] limit;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_out, tx_busy, tx_done;

    int n_assert = 0;
    int n_fail   = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_BITS(DB), .STOP_BITS(SB), .CNT_W(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_limit    (limit),
        .i_tx_start (tx_start),
        .i_tx_data  (tx_data),
        .o_tx_out   (tx_out),
        .o_tx_busy  (tx_busy),
        .o_tx_done  (tx_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected tx_out for every cycle of one frame.
    task automatic build(input logic [7:0] d, input int lim);
        int L;
        L = lim + 1;
        exp_q.delete();
        repeat (L) exp_q.push_back(1'b0);
        for (int i = 0; i < DB; i++) repeat (L) exp_q.push_back(d[i]);
        if (P == 1) repeat (L) exp_q.push_back(^d);
        repeat (L * SB) exp_q.push_back(1'b1);
    endtask

    // Drive a request, take the accept edge, leave tx_start held if asked.
    task automatic accept(input logic [7:0] d, input int lim, input bit hold);
        tx_data  = d;
        limit    = lim;
        tx_start = 1'b1;
        @(posedge clk); #1;
        if (!hold) tx_start = 1'b0;
        build(d, lim);
    endtask

    // Check ncyc cycles of the frame; optionally disturb inputs mid-frame.
    task automatic check_frame(input int ncyc, input bit perturb, input bit hold);
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            chk($sformatf("out[%0d]", k), tx_out, exp_q[k]);
            chk($sformatf("busy[%0d]", k), tx_busy, 1);
            chk($sformatf("done[%0d]", k), tx_done, 0);
            if (perturb && k == 2) begin
                tx_data = 8'($urandom);
                limit   = $urandom_range(0, 9);
                if (!hold) tx_start = 1'b1;
            end
            if (perturb && k == 3 && !hold) tx_start = 1'b0;
        end
    endtask

    task automatic check_done();
        @(posedge clk); #1;
        chk("done_out", tx_out, 1);
        chk("done_busy", tx_busy, 0);
        chk("done_pulse", tx_done, 1);
    endtask

    task automatic check_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_out", tx_out, 1);
            chk("idle_busy", tx_busy, 0);
            chk("idle_done", tx_done, 0);
        end
    endtask

    initial begin
        logic [7:0] d;
        int lim;
        rst = 1'b1; limit = 0; tx_start = 1'b0; tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", tx_out, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        rst = 1'b0;
        check_idle(20);

        // Directed frames.
        accept(8'hA5, 3, 0);
        chk("len_A5", exp_q.size(), (10 + P) * 4);
        check_frame(exp_q.size(), 0, 0);
        check_done();
        check_idle(3);

        accept(8'h07, 3, 0);
        check_frame(exp_q.size(), 0, 0);
        check_done();
        check_idle(2);

        // Random frames with ignored mid-frame start pulses and input changes.
        for (int f = 0; f < 8; f++) begin
            d   = 8'($urandom);
            lim = $urandom_range(0, 4);
            accept(d, lim, 0);
            check_frame(exp_q.size(), 1, 0);
            check_done();
            check_idle($urandom_range(1, 3));
        end

        // Back-to-back frames with tx_start held, limit 0.
        for (int f = 0; f < 5; f++) begin
            accept(8'($urandom), 0, 1);
            check_frame(exp_q.size(), 1, 1);
            check_done();
        end
        tx_start = 1'b0;
        check_idle(3);

        // Reset during the third data bit (limit 3: data bit 2 spans cycles 12..15).
        accept(8'h3C, 3, 0);
        check_frame(14, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out", tx_out, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_done", tx_done, 0);
        rst = 1'b0;
        check_idle(6);
        accept(8'hC3, 2, 0);
        check_frame(exp_q.size(), 0, 0);
        check_done();
        check_idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
